pipeline_perf_monitor: RTL and testbench
========================================

Name: pipeline_perf_monitor

Overview:
- Synthesisable performance monitor for the five-stage MIPS pipeline.
- Counts clock cycles, retired instructions and N_EVT auxiliary event channels (stalls, taken branches, flushes, ...).
- Detects a program-end condition on a watched register value and freezes all counters at that point.
- Then computes fixed-point CPI with a bit-serial divider. Sits beside the pipeline core, fed from its control signals and register-file read-out.

Parameters:
- CNT_W, 32, width of every counter.
- N_EVT, 4, number of auxiliary event channels.
- DATA_W, 32, width of watched register data.
- HALT_VALUE, 1, watched value that ends the run.
- FRAC_W, 8, fractional bits of the CPI result.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  counting enable; low = hold all counters, halt detection disabled.
- clr  in  1  synchronous clear; returns the block to RUN with zeroed state.
- reg_write, mem_read, mem_write, branch  in  1 each  decoded control of the instruction in decode.
- pc_write  in  1  low = pipeline stall.
- evt  in  N_EVT  per-channel event strobes, one count per cycle when high.
- watch_valid  in  1  watch_data is meaningful this cycle.
- watch_data  in  DATA_W  watched register value.
- cycle_count  out  CNT_W  cycles counted.
- instr_count  out  CNT_W  instructions retired.
- evt_count  out  N_EVT*CNT_W  channel i occupies bits [i*CNT_W +: CNT_W].
- overflow  out  1  sticky: some counter saturated.
- halted  out  1  run ended, counters frozen.
- cpi  out  CNT_W+FRAC_W  floor((cycle_count<<FRAC_W)/instr_count).
- cpi_valid  out  1  cpi result final.
- div_zero  out  1  instr_count was 0 at halt.

Behaviour:
- Reset (reset=0, asynchronous):
  - State RUN.
  - All counters, cpi, overflow, halted, cpi_valid and div_zero are 0.
- Retire condition: (reg_write|mem_read|mem_write|branch) & pc_write.
- States:
  - RUN:
    - If enable=1, each edge: cycle_count +1; instr_count +1 if retire; evt_count[i] +1 if evt[i].
    - Halt condition: enable & watch_valid & (watch_data==HALT_VALUE), sampled at edge T.
    - On halt, the increments of cycle T are applied. State becomes DIVIDE, halted=1 from T, and the divider is loaded with dividend cycle_count<<FRAC_W and divisor instr_count, using the post-increment values.
  - DIVIDE:
    - Restoring division, one quotient bit per edge, Q=CNT_W+FRAC_W edges.
    - At edge T+Q, cpi is updated and cpi_valid=1; state becomes DONE.
    - cpi is held at 0 until cpi_valid.
    - Counters are frozen; inputs are ignored.
  - DONE: all outputs held until clr or reset.
- Saturation: any counter at all-ones holds all-ones and sets overflow (sticky until clr/reset). The divider uses the saturated values.
- Divide by zero: if instr_count==0 at halt, DIVIDE still takes Q cycles (uniform latency). The result is cpi all-ones, with div_zero=1 and cpi_valid=1.
- clr=1 at any edge, any state:
  - All counters, flags and the divider are zeroed; state becomes RUN.
  - clr has priority over counting and over halt detection in the same cycle.
- enable=0 in RUN: nothing changes, including cycle_count. enable has no effect in DIVIDE or DONE.
- A halt that coincides with the counter saturation edge: the saturated value is used and overflow=1.
- reset asserted mid-DIVIDE: immediate return to the reset state; the partial quotient is discarded.

Test Plan:
- Reset, enable=1, 10 cycles with retire on 6 (pc_write=1), then watch_data=1 with watch_valid=1 on cycle 10 -> cycle_count=10, instr_count=6, halted=1, and after 40 cycles cpi_valid=1 with cpi=0x1AA (1.664, Q8).
- Stalls: reg_write=1, pc_write=0 for 5 of 8 cycles, retire on the other 3, halt at cycle 8 -> instr_count=3, cpi=0x2AA.
- CNT_W=4, 20 cycles before halt -> cycle_count=15, overflow=1, counters frozen thereafter.
- No retire, halt at cycle 4 -> div_zero=1, cpi all-ones, cpi_valid 40 cycles after halted.
- evt[2] high for 7 cycles, enable low for 3 of 12 cycles -> evt_count[2] reflects only enabled cycles, cycle_count=9.
- clr asserted during DIVIDE, with a halt match in the same cycle -> state RUN, all outputs 0, no halt; a subsequent run then counts from zero.
- reset pulsed low during DONE -> all outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/pipeline_perf_monitor.sv
// Performance monitor beside the 5-stage MIPS pipeline: saturating cycle/instruction/event
// counters, halt detection on a watched register value, then a bit-serial restoring CPI divide.
module pipeline_perf_monitor #(
    parameter int CNT_W      = 32,
    parameter int N_EVT      = 4,
    parameter int DATA_W     = 32,
    parameter int HALT_VALUE = 1,
    parameter int FRAC_W     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clr,
    input  logic                      reg_write,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic                      branch,
    input  logic                      pc_write,
    input  logic [N_EVT-1:0]          evt,
    input  logic                      watch_valid,
    input  logic [DATA_W-1:0]         watch_data,
    output logic [CNT_W-1:0]          cycle_count,
    output logic [CNT_W-1:0]          instr_count,
    output logic [N_EVT*CNT_W-1:0]    evt_count,
    output logic                      overflow,
    output logic                      halted,
    output logic [CNT_W+FRAC_W-1:0]   cpi,
    output logic                      cpi_valid,
    output logic                      div_zero
);
    localparam int Q   = CNT_W + FRAC_W;
    localparam int SW  = $clog2(Q);
    localparam int NC  = N_EVT + 2;

    typedef enum logic [1:0] {RUN, DIVIDE, DONE} state_t;

    state_t                   state;
    // slot 0 = cycles, slot 1 = retired instructions, slots 2.. = event channels
    logic [NC-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NC-1:0]            inc_v, sat_v;
    logic                     retire, count_en, halt_hit;

    logic [CNT_W-1:0]         rem, dvs, rem_n;
    logic [Q-1:0]             quo;
    logic [SW-1:0]            step;
    logic                     dz;
    logic [CNT_W:0]           trial, diff;
    logic                     qbit;

    assign retire   = (reg_write | mem_read | mem_write | branch) & pc_write;
    assign inc_v    = {evt, retire, 1'b1};
    assign count_en = (state == RUN) && enable;
    assign halt_hit = count_en && watch_valid && (watch_data == DATA_W'(HALT_VALUE));

    for (genvar g = 0; g < NC; g++) begin : g_cnt
        assign cnt_d[g] = (inc_v[g] && !(&cnt_q[g])) ? cnt_q[g] + 1'b1 : cnt_q[g];
        assign sat_v[g] = &cnt_d[g];
    end

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    assign trial = {rem, quo[Q-1]};
    assign diff  = trial - {1'b0, dvs};
    assign qbit  = (trial >= {1'b0, dvs});
    assign rem_n = qbit ? diff[CNT_W-1:0] : trial[CNT_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            cnt_q     <= '0;
            overflow  <= 1'b0;
            halted    <= 1'b0;
            cpi       <= '0;
            cpi_valid <= 1'b0;
            div_zero  <= 1'b0;
            rem       <= '0;
            dvs       <= '0;
            quo       <= '0;
            step      <= '0;
            dz        <= 1'b0;
        end else if (clr) begin
            state     <= RUN;
            cnt_q     <= '0;
            overflow  <= 1'b0;
            halted    <= 1'b0;
            cpi       <= '0;
            cpi_valid <= 1'b0;
            div_zero  <= 1'b0;
            rem       <= '0;
            dvs       <= '0;
            quo       <= '0;
            step      <= '0;
            dz        <= 1'b0;
        end else begin
            case (state)
                RUN: if (enable) begin
                    cnt_q    <= cnt_d;
                    overflow <= overflow | (|sat_v);
                    if (halt_hit) begin
                        // divider sees the post-increment (and saturated) values
                        state  <= DIVIDE;
                        halted <= 1'b1;
                        rem    <= '0;
                        quo    <= {cnt_d[0], {FRAC_W{1'b0}}};
                        dvs    <= cnt_d[1];
                        dz     <= (cnt_d[1] == '0);
                        step   <= '0;
                    end
                end
                DIVIDE: begin
                    rem  <= rem_n;
                    quo  <= {quo[Q-2:0], qbit};
                    step <= step + 1'b1;
                    if (step == SW'(Q - 1)) begin
                        state     <= DONE;
                        cpi_valid <= 1'b1;
                        div_zero  <= dz;
                        cpi       <= dz ? {Q{1'b1}} : {quo[Q-2:0], qbit};
                    end
                end
                default: ;
            endcase
        end
    end

    assign cycle_count = cnt_q[0];
    assign instr_count = cnt_q[1];
    assign evt_count   = cnt_q[NC-1:2];
endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Randomized scoreboard bench: a 32-bit and a 4-bit monitor share stimulus; expected results
// come from plain counting arithmetic and are checked when each DUT raises cpi_valid.
module tb_pipeline_perf_monitor;
    typedef struct packed {
        logic [63:0]      cyc;
        logic [63:0]      ins;
        logic [3:0][63:0] ev;
        logic             ovf;
        logic [63:0]      cpi;
        logic             dz;
    } exp_t;

    logic clk, reset, enable, clr, reg_write, mem_read, mem_write, branch, pc_write;
    logic [3:0]  evt;
    logic        watch_valid;
    logic [31:0] watch_data;

    logic [31:0]  c32_cyc, c32_ins;
    logic [127:0] c32_ev;
    logic         c32_ovf, c32_halted, c32_cpi_valid, c32_dz;
    logic [39:0]  c32_cpi;
    logic [3:0]   c4_cyc, c4_ins;
    logic [15:0]  c4_ev;
    logic         c4_ovf, c4_halted, c4_cpi_valid, c4_dz;
    logic [11:0]  c4_cpi;

    int total = 0, bad = 0;
    exp_t q32[$], q4[$];

    pipeline_perf_monitor #(.CNT_W(32)) d32 (
        .clk(clk), .reset(reset), .enable(enable), .clr(clr), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .pc_write(pc_write),
        .evt(evt), .watch_valid(watch_valid), .watch_data(watch_data),
        .cycle_count(c32_cyc), .instr_count(c32_ins), .evt_count(c32_ev), .overflow(c32_ovf),
        .halted(c32_halted), .cpi(c32_cpi), .cpi_valid(c32_cpi_valid), .div_zero(c32_dz));

    pipeline_perf_monitor #(.CNT_W(4)) d4 (
        .clk(clk), .reset(reset), .enable(enable), .clr(clr), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .pc_write(pc_write),
        .evt(evt), .watch_valid(watch_valid), .watch_data(watch_data),
        .cycle_count(c4_cyc), .instr_count(c4_ins), .evt_count(c4_ev), .overflow(c4_ovf),
        .halted(c4_halted), .cpi(c4_cpi), .cpi_valid(c4_cpi_valid), .div_zero(c4_dz));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(int w, logic [63:0] c, logic [63:0] n, logic [3:0][63:0] e);
        exp_t r;
        logic [63:0] mx;
        mx    = (64'd1 << w) - 1;
        r.ovf = (c >= mx) || (n >= mx);
        r.cyc = (c > mx) ? mx : c;
        r.ins = (n > mx) ? mx : n;
        for (int j = 0; j < 4; j++) begin
            r.ev[j] = (e[j] > mx) ? mx : e[j];
            if (e[j] >= mx) r.ovf = 1'b1;
        end
        r.dz  = (r.ins == 0);
        r.cpi = r.dz ? (64'd1 << (w + 8)) - 1 : (r.cyc << 8) / r.ins;
        return r;
    endfunction

    task automatic score(string t, exp_t e, logic [63:0] cyc, logic [63:0] ins,
                         logic [3:0][63:0] ev, logic ovf, logic [63:0] cpi, logic dz,
                         int lat, int q);
        cmp({t, "_cycle"}, cyc, e.cyc);
        cmp({t, "_instr"}, ins, e.ins);
        for (int j = 0; j < 4; j++) cmp($sformatf("%s_evt%0d", t, j), ev[j], e.ev[j]);
        cmp({t, "_overflow"}, 64'(ovf), 64'(e.ovf));
        cmp({t, "_cpi"}, cpi, e.cpi);
        cmp({t, "_div_zero"}, 64'(dz), 64'(e.dz));
        cmp({t, "_latency"}, 64'(lat), 64'(q));
    endtask

    // Monitors: compare against the oldest expectation whenever cpi_valid rises.
    initial begin
        int hc = 0;
        logic pv = 0;
        logic [3:0][63:0] v;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hc = 0; pv = 0;
            end else begin
                if (c32_cpi_valid && !pv) begin
                    cmp("m32_expected", 64'(q32.size() > 0), 64'd1);
                    if (q32.size() > 0) begin
                        e = q32.pop_front();
                        for (int j = 0; j < 4; j++) v[j] = 64'(c32_ev[j*32 +: 32]);
                        score("m32", e, 64'(c32_cyc), 64'(c32_ins), v, c32_ovf, 64'(c32_cpi),
                              c32_dz, hc, 40);
                    end
                end
                if (!c32_cpi_valid && c32_cpi != 0) cmp("m32_cpi_held0", 64'(c32_cpi), 0);
                if (!c32_halted) hc = 0;
                else if (!c32_cpi_valid) hc++;
                pv = c32_cpi_valid;
            end
        end
    end

    initial begin
        int hc = 0;
        logic pv = 0;
        logic [3:0][63:0] v;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hc = 0; pv = 0;
            end else begin
                if (c4_cpi_valid && !pv) begin
                    cmp("m4_expected", 64'(q4.size() > 0), 64'd1);
                    if (q4.size() > 0) begin
                        e = q4.pop_front();
                        for (int j = 0; j < 4; j++) v[j] = 64'(c4_ev[j*4 +: 4]);
                        score("m4", e, 64'(c4_cyc), 64'(c4_ins), v, c4_ovf, 64'(c4_cpi),
                              c4_dz, hc, 12);
                    end
                end
                if (!c4_cpi_valid && c4_cpi != 0) cmp("m4_cpi_held0", 64'(c4_cpi), 0);
                if (!c4_halted) hc = 0;
                else if (!c4_cpi_valid) hc++;
                pv = c4_cpi_valid;
            end
        end
    end

    task automatic chk_zero(string t);
        cmp({t, "_c32_cycle"}, 64'(c32_cyc), 0);
        cmp({t, "_c32_instr"}, 64'(c32_ins), 0);
        cmp({t, "_c32_evt"}, 64'(|c32_ev), 0);
        cmp({t, "_c32_flags"}, 64'({c32_ovf, c32_halted, c32_cpi_valid, c32_dz}), 0);
        cmp({t, "_c32_cpi"}, 64'(c32_cpi), 0);
        cmp({t, "_c4_all"}, 64'({c4_cyc, c4_ins, c4_ev, c4_ovf, c4_halted, c4_cpi_valid,
                                 c4_dz, c4_cpi}), 0);
    endtask

    task automatic rand_inputs();
        enable      = 1'($urandom_range(1));
        reg_write   = 1'($urandom_range(1));
        mem_read    = 1'($urandom_range(1));
        mem_write   = 1'($urandom_range(1));
        branch      = 1'($urandom_range(1));
        pc_write    = 1'($urandom_range(1));
        evt         = 4'($urandom);
        watch_valid = 1'($urandom_range(1));
        watch_data  = 32'($urandom_range(1));
        clr         = 1'b0;
    endtask

    // ncyc cycles including the halt cycle; nret>=0 retires on the first nret cycles exactly.
    // endk: 0 = clr after DONE, 1 = async reset in DONE, 2 = clr+halt match during DIVIDE.
    task automatic run(int ncyc, int en_pct, int nret, int endk, output logic [63:0] cp);
        logic [63:0]      mc = 0, mi = 0;
        logic [3:0][63:0] me = '0;
        exp_t e32, e4;
        int k;
        cp = 0;
        for (int i = 0; i < ncyc; i++) begin
            logic last;
            last   = (i == ncyc - 1);
            enable = last ? 1'b1 : 1'(int'($urandom_range(99)) < en_pct);
            if (nret >= 0) begin
                reg_write = 1; mem_read = 0; mem_write = 0; branch = 0;
                pc_write  = 1'(i < nret);
            end else begin
                reg_write = 1'($urandom_range(1)); mem_read = 1'($urandom_range(1));
                mem_write = 1'($urandom_range(1)); branch   = 1'($urandom_range(1));
                pc_write  = 1'($urandom_range(3) != 0);
            end
            evt         = 4'($urandom);
            watch_valid = last ? 1'b1 : 1'($urandom_range(1));
            // a matching value is only offered while counting is disabled
            watch_data  = last ? 32'd1 : (enable ? 32'($urandom_range(9) + 2)
                                                 : 32'($urandom_range(2)));
            clr = 0;
            if (enable) begin
                mc++;
                if ((reg_write | mem_read | mem_write | branch) & pc_write) mi++;
                for (int j = 0; j < 4; j++) if (evt[j]) me[j]++;
            end
            if (last) begin
                e32 = mk(32, mc, mi, me);
                e4  = mk(4, mc, mi, me);
                if (endk != 2) begin
                    q32.push_back(e32);
                    q4.push_back(e4);
                end
            end
            @(posedge clk); #1;
        end
        if (endk == 2) begin
            k = $urandom_range(1, 20);
            if (k >= 12) q4.push_back(e4);
            for (int t = 0; t < k; t++) begin rand_inputs(); @(posedge clk); #1; end
            rand_inputs();
            enable = 1; watch_valid = 1; watch_data = 1; clr = 1;
            @(posedge clk); #1;
            clr = 0; enable = 0;
            chk_zero("abort");
            @(posedge clk); #1;
            chk_zero("abort_hold");
            return;
        end
        for (int t = 0; t < 60 && !c32_cpi_valid; t++) begin
            rand_inputs(); @(posedge clk); #1;
        end
        cmp("div_done_in_time", 64'(c32_cpi_valid), 1);
        cp = 64'(c32_cpi);
        for (int t = 0; t < 3; t++) begin rand_inputs(); @(posedge clk); #1; end
        cmp("done_hold_c32_cycle", 64'(c32_cyc), e32.cyc);
        cmp("done_hold_c32_cpi", 64'(c32_cpi), e32.cpi);
        cmp("done_hold_c4_cycle", 64'(c4_cyc), e4.cyc);
        cmp("done_hold_c4_instr", 64'(c4_ins), e4.ins);
        enable = 0;
        if (endk == 1) begin
            #2 reset = 0;
            #1 chk_zero("async_reset");
            @(posedge clk); #1;
            reset = 1;
        end else begin
            clr = 1;
            @(posedge clk); #1;
            clr = 0;
            chk_zero("clr");
        end
    endtask

    initial begin
        logic [63:0] cp;
        reset = 0; enable = 0; clr = 0; reg_write = 0; mem_read = 0; mem_write = 0;
        branch = 0; pc_write = 0; evt = 0; watch_valid = 0; watch_data = 0;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        reset = 1;
        @(posedge clk); #1;

        run(10, 100, 6, 0, cp);  cmp("plan_cpi_1aa", cp, 64'h1AA);
        run(8, 100, 3, 0, cp);   cmp("plan_cpi_2aa", cp, 64'h2AA);
        run(20, 100, -1, 0, cp);
        run(4, 100, 0, 0, cp);   cmp("plan_divzero_cpi", cp, 64'hFF_FFFF_FFFF);
        run(12, 75, -1, 0, cp);
        run(9, 100, -1, 2, cp);
        run(10, 100, -1, 0, cp);
        run(7, 100, -1, 1, cp);
        run(1, 100, -1, 0, cp);
        for (int r = 0; r < 12; r++)
            run($urandom_range(1, 30), $urandom_range(50, 100), -1, $urandom_range(2), cp);

        repeat (5) @(posedge clk);
        #1;
        cmp("q32_drained", 64'(q32.size()), 0);
        cmp("q4_drained", 64'(q4.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
